// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg: shared constants for the pipelined fixed-point multiplier
package mult_pipe_pkg;
  localparam int MAX_LATENCY = 8;
  localparam bit ROUND_TRUNC = 1'b0;
  localparam bit ROUND_HALF_UP = 1'b1;
  localparam bit SAT_WRAP = 1'b0;
  localparam bit SAT_CLAMP = 1'b1;
endpackage

// File: rtl/mult_pipe_post.sv
// mult_pipe_post: round, scale and saturate/wrap a full-width product, flagging overflow
module mult_pipe_post
  import mult_pipe_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int OUT_W = 16,
  parameter int FRAC = 15,
  parameter bit SIGNED = 1'b1,
  parameter bit ROUND = 1'b1,
  parameter bit SAT = 1'b1
) (
  input  logic [2*IN_W-1:0] p,
  output logic [OUT_W-1:0]  data,
  output logic              ovf
);
  localparam int W1 = 2*IN_W+1;
  localparam bit DO_RND = (ROUND == ROUND_HALF_UP) && (FRAC > 0);
  localparam logic [W1-1:0] RC = DO_RND ? W1'(1) << (DO_RND ? FRAC-1 : 0) : '0;
  logic [W1-1:0] ext, sum, r;
  logic signed [W1-1:0] rs;
  logic fits;
  // one extra bit keeps the rounding add from ever overflowing
  always_comb begin
    ext = {SIGNED & p[2*IN_W-1], p};
    sum = ext + RC;
    rs = $signed(sum) >>> FRAC;
    r = SIGNED ? rs : sum >> FRAC;
    fits = SIGNED ? (&r[W1-1:OUT_W-1] || !(|r[W1-1:OUT_W-1])) : !(|r[W1-1:OUT_W]);
    ovf = !fits;
    data = (fits || SAT == SAT_WRAP) ? r[OUT_W-1:0]
         : (SIGNED && r[W1-1]) ? {1'b1, {(OUT_W-1){1'b0}}}
         : {!SIGNED, {(OUT_W-1){1'b1}}};
  end
endmodule

// File: rtl/mult_pipe.sv
// mult_pipe: pipelined fixed-point multiplier with valid/ready backpressure and flush
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int OUT_W = 16,
  parameter int FRAC = 15,
  parameter int LATENCY = 2,
  parameter bit SIGNED = 1'b1,
  parameter bit ROUND = ROUND_HALF_UP,
  parameter bit SAT = SAT_CLAMP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);
  localparam int PW = 2*IN_W;
  logic adv;
  logic signed [PW-1:0] prod_s;
  logic [PW-1:0] prod_u;
  logic v_up [0:LATENCY-1];
  logic [PW-1:0] p_up [0:LATENCY-1];
  logic vld_q [1:LATENCY-1];
  logic vld_d [1:LATENCY-1];
  logic [PW-1:0] p_q [1:LATENCY-1];
  logic [PW-1:0] p_d [1:LATENCY-1];
  logic out_valid_q, out_valid_d, out_ovf_q, out_ovf_d, post_ovf;
  logic [OUT_W-1:0] out_data_q, out_data_d, post_data;
  always_comb begin
    adv = !out_valid_q || out_ready;
    in_ready = adv || flush;
    prod_s = $signed({{IN_W{in_a[IN_W-1]}}, in_a}) * $signed({{IN_W{in_b[IN_W-1]}}, in_b});
    prod_u = {{IN_W{1'b0}}, in_a} * {{IN_W{1'b0}}, in_b};
    v_up[0] = in_valid;
    p_up[0] = SIGNED ? prod_s : prod_u;
    for (int i = 1; i < LATENCY; i++) begin
      v_up[i] = vld_q[i];
      p_up[i] = p_q[i];
    end
    out_valid_d = flush ? 1'b0 : adv ? v_up[LATENCY-1] : out_valid_q;
    out_data_d = adv ? post_data : out_data_q;
    out_ovf_d = adv ? post_ovf : out_ovf_q;
  end
  // stage 1 holds the raw product, later stages only delay it
  for (genvar s = 1; s < LATENCY; s++) begin : g_stage
    always_comb begin
      vld_d[s] = flush ? 1'b0 : adv ? v_up[s-1] : vld_q[s];
      p_d[s] = adv ? p_up[s-1] : p_q[s];
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q[s] <= 1'b0;
        p_q[s] <= '0;
      end else begin
        vld_q[s] <= vld_d[s];
        p_q[s] <= p_d[s];
      end
    end
  end
  mult_pipe_post #(
    .IN_W(IN_W), .OUT_W(OUT_W), .FRAC(FRAC), .SIGNED(SIGNED), .ROUND(ROUND), .SAT(SAT)
  ) u_post (
    .p(p_q[LATENCY-1]),
    .data(post_data),
    .ovf(post_ovf)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ovf = out_ovf_q;
endmodule
